// File: rtl/nes_fb_wr_arb.sv
// nes_fb_wr_arb: framebuffer write-port arbiter and frame sequencer (clk_nes domain).
// Merges the PPU pixel stream (priority, no backpressure) with a valid/ready
// host/OSD writer. It aligns PPU writes to whole frames, implements freeze-frame
// and flags frames whose pixel count differs from FRAME_PIX.
// Optional feature: define NES_FB_DOUBLE_BUFFER_EN to flip fb_bank after every
// complete RUN frame. Without it, fb_bank is tied to 0 (single buffer).
module nes_fb_wr_arb #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 6,
  parameter int FRAME_PIX = 61440
) (
  input  logic              clk_nes,
  input  logic              rst_nes_n,
  input  logic              ppu_we,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [DATA_W-1:0] ppu_data,
  input  logic              ppu_vbl,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              freeze,
  input  logic              clr_err,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic              fb_bank,
  output logic              frozen,
  output logic [15:0]       frame_cnt,
  output logic              frame_short
);

  typedef enum logic [1:0] {
    WAIT_VBL = 2'd0,
    RUN      = 2'd1,
    FROZEN   = 2'd2
  } state_t;

  localparam logic [15:0] FRAME_PIX_C = 16'(FRAME_PIX);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pix_cnt;
  logic        fwd_p0;
  logic        host_xfer_p0;
  logic        frame_full;
  logic        short_set;

  // Saturating increment so a runaway PPU cannot wrap the pixel count back to a legal value.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign frame_full = (pix_cnt == FRAME_PIX_C);
  assign short_set  = ppu_vbl && (state == RUN) && !frame_full;

  // Next-state and per-cycle arbitration: a forwarded PPU pixel always wins the port.
  always_comb begin
    state_nxt    = state;
    fwd_p0       = ppu_we && (state == RUN);
    host_ready   = !fwd_p0;
    host_xfer_p0 = host_valid && !fwd_p0;
    case (state)
      WAIT_VBL: if (ppu_vbl) state_nxt = freeze ? FROZEN : RUN;
      RUN:      if (ppu_vbl && freeze) state_nxt = FROZEN;
      FROZEN:   if (ppu_vbl && !freeze) state_nxt = RUN;
      default:  state_nxt = WAIT_VBL;
    endcase
  end

  // State register; frozen mirrors the registered state.
  always_ff @(posedge clk_nes or negedge rst_nes_n) begin
    if (!rst_nes_n) begin
      state  <= WAIT_VBL;
      frozen <= 1'b0;
    end else begin
      state  <= state_nxt;
      frozen <= (state_nxt == FROZEN);
    end
  end

  // ---- stage p0 -> p1: registered framebuffer write port ----
  // Address/data hold their last value between writes.
  always_ff @(posedge clk_nes or negedge rst_nes_n) begin
    if (!rst_nes_n) begin
      fb_we    <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
    end else begin
      fb_we <= fwd_p0 || host_xfer_p0;
      if (fwd_p0) begin
        fb_waddr <= ppu_addr;
        fb_wdata <= ppu_data;
      end else if (host_xfer_p0) begin
        fb_waddr <= host_addr;
        fb_wdata <= host_data;
      end
    end
  end

  // Per-frame pixel counter; a pixel coinciding with ppu_vbl opens the new frame.
  always_ff @(posedge clk_nes or negedge rst_nes_n) begin
    if (!rst_nes_n) begin
      pix_cnt <= 16'd0;
    end else if (ppu_vbl) begin
      pix_cnt <= fwd_p0 ? 16'd1 : 16'd0;
    end else if (fwd_p0) begin
      pix_cnt <= sat_inc16(pix_cnt);
    end
  end

  // Frame counter and sticky short-frame flag; a new error beats a same-cycle clear.
  always_ff @(posedge clk_nes or negedge rst_nes_n) begin
    if (!rst_nes_n) begin
      frame_cnt   <= 16'd0;
      frame_short <= 1'b0;
    end else begin
      if (ppu_vbl) frame_cnt <= frame_cnt + 16'd1;
      if (short_set) frame_short <= 1'b1;
      else if (clr_err) frame_short <= 1'b0;
    end
  end

`ifdef NES_FB_DOUBLE_BUFFER_EN
  logic bank_flip;
  // Only a complete frame that keeps running hands its bank to the display.
  assign bank_flip = ppu_vbl && (state == RUN) && (state_nxt == RUN) && frame_full;

  // Write-bank toggle; the display reads the opposite bank.
  always_ff @(posedge clk_nes or negedge rst_nes_n) begin
    if (!rst_nes_n) fb_bank <= 1'b0;
    else if (bank_flip) fb_bank <= !fb_bank;
  end
`else
  assign fb_bank = 1'b0;
`endif

endmodule

// File: tb/tb_nes_fb_wr_arb.sv
// Testbench for nes_fb_wr_arb: randomized PPU/host traffic checked against a
// frame-level behavioural model. FRAME_PIX is reduced so whole frames stay short.
module tb_nes_fb_wr_arb;
  localparam int AW = 16;
  localparam int DW = 6;
  localparam int FP = 64;
  localparam int M_WAIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_FRZ  = 2;
  localparam int NEVER  = 1 << 20;

  logic          clk_nes = 1'b0;
  logic          rst_nes_n;
  logic          ppu_we;
  logic [AW-1:0] ppu_addr;
  logic [DW-1:0] ppu_data;
  logic          ppu_vbl;
  logic          host_valid;
  logic          host_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          freeze;
  logic          clr_err;
  logic          fb_we;
  logic [AW-1:0] fb_waddr;
  logic [DW-1:0] fb_wdata;
  logic          fb_bank;
  logic          frozen;
  logic [15:0]   frame_cnt;
  logic          frame_short;

  always #5 clk_nes = ~clk_nes;

  nes_fb_wr_arb #(.ADDR_W(AW), .DATA_W(DW), .FRAME_PIX(FP)) dut (
    .clk_nes(clk_nes), .rst_nes_n(rst_nes_n),
    .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_data(ppu_data), .ppu_vbl(ppu_vbl),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data),
    .freeze(freeze), .clr_err(clr_err),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_bank(fb_bank),
    .frozen(frozen), .frame_cnt(frame_cnt), .frame_short(frame_short)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int            m_mode;
  int            m_cnt;
  bit            m_short;
  logic [15:0]   m_fcnt;
  bit            m_bank;
  bit            e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  bit            e_ready;
  bit            e_host;
  logic          a_ready;
  logic [AW+DW-1:0] hq[$];
  int            hcount;
  int            rdy_lo;
  int            we_cnt;

  task automatic model_reset();
    m_mode = M_WAIT; m_cnt = 0; m_short = 0; m_fcnt = 16'd0; m_bank = 0;
    e_we = 0; e_addr = '0; e_data = '0; e_host = 0;
  endtask

  // Drive one cycle of inputs, predict its effect, then advance past the clock edge.
  task automatic cyc(input bit pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                     input bit vbl, input bit hv, input logic [AW-1:0] ha,
                     input logic [DW-1:0] hd, input bit frz, input bit clr);
    bit fwd;
    bit acc;
    bit full;
    ppu_we = pwe; ppu_addr = pa; ppu_data = pd; ppu_vbl = vbl;
    host_valid = hv; host_addr = ha; host_data = hd; freeze = frz; clr_err = clr;
    #1;
    a_ready = host_ready;
    fwd = pwe && (m_mode == M_RUN);
    e_ready = !fwd;
    acc = hv && e_ready;
    e_host = 0;
    if (fwd) begin
      e_we = 1; e_addr = pa; e_data = pd;
    end else if (acc) begin
      e_we = 1; e_addr = ha; e_data = hd; e_host = 1;
      hq.push_back({ha, hd});
    end else begin
      e_we = 0;
    end
    if (vbl) begin
      full = (m_cnt == FP);
      if (m_mode == M_RUN && !full) m_short = 1;
      else if (clr) m_short = 0;
`ifdef NES_FB_DOUBLE_BUFFER_EN
      if (m_mode == M_RUN && !frz && full) m_bank = !m_bank;
`endif
      m_fcnt = m_fcnt + 16'd1;
      case (m_mode)
        M_WAIT:  m_mode = frz ? M_FRZ : M_RUN;
        M_RUN:   m_mode = frz ? M_FRZ : M_RUN;
        default: m_mode = frz ? M_FRZ : M_RUN;
      endcase
      m_cnt = fwd ? 1 : 0;
    end else begin
      if (clr) m_short = 0;
      if (fwd && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk_nes);
    #1;
  endtask

  task automatic idle(input bit clr);
    cyc(0, '0, '0, 0, 0, '0, '0, 0, clr);
  endtask

  // One frame: npix strobes every 4 cycles, then ppu_vbl; every cycle compared to the model.
  task automatic run_frame(input int npix, input int frz_from, input bit frz_end,
                           input bit host_on, input bit clr_at_vbl);
    logic [18:0] exp_st;
    logic [AW+DW-1:0] hexp;
    for (int t = 0; t <= 4 * npix; t++) begin
      bit vbl;
      bit pwe;
      bit frz;
      vbl = (t == 4 * npix);
      pwe = ((t % 4) == 0) && !vbl;
      frz = vbl ? frz_end : ((t / 4) >= frz_from);
      cyc(pwe, AW'($urandom), DW'($urandom), vbl, host_on, AW'($urandom), DW'($urandom),
          frz, vbl && clr_at_vbl);
      checks++;
      if (a_ready !== e_ready) begin
        errors++;
        $display("FAIL host_ready t=%0d: got %b want %b", t, a_ready, e_ready);
      end
      if (a_ready === 1'b0) rdy_lo++;
      checks++;
      if ({fb_we, fb_waddr, fb_wdata} !== {e_we, e_addr, e_data}) begin
        errors++;
        $display("FAIL fb_port t=%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                 t, fb_we, fb_waddr, fb_wdata, e_we, e_addr, e_data);
      end
      if (fb_we === 1'b1) we_cnt++;
      exp_st = {(m_mode == M_FRZ) ? 1'b1 : 1'b0, m_bank ? 1'b1 : 1'b0,
                m_short ? 1'b1 : 1'b0, m_fcnt};
      checks++;
      if ({frozen, fb_bank, frame_short, frame_cnt} !== exp_st) begin
        errors++;
        $display("FAIL status t=%0d: got %h want %h", t,
                 {frozen, fb_bank, frame_short, frame_cnt}, exp_st);
      end
      if (e_host) begin
        checks++;
        if (hq.size() == 0) begin
          errors++;
          $display("FAIL host_order t=%0d: got write %h want none queued", t, {fb_waddr, fb_wdata});
        end else begin
          hexp = hq.pop_front();
          if ({fb_waddr, fb_wdata} !== hexp) begin
            errors++;
            $display("FAIL host_order t=%0d: got %h want %h", t, {fb_waddr, fb_wdata}, hexp);
          end else begin
            hcount++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({fb_we, fb_waddr, fb_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_port: got %h want 0", {fb_we, fb_waddr, fb_wdata});
    end
    checks++;
    if ({fb_bank, frozen, frame_short} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {fb_bank, frozen, frame_short});
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
    end
  endtask

  task automatic test_wait_vbl();
    for (int i = 0; i < 3; i++) begin
      cyc(1, AW'($urandom), DW'($urandom), 0, 0, '0, '0, 0, 0);
      checks++;
      if (fb_we !== 1'b0) begin
        errors++;
        $display("FAIL wait_discard %0d: got fb_we %b want 0", i, fb_we);
      end
      idle(0);
    end
    cyc(0, '0, '0, 1, 0, '0, '0, 0, 0);
    checks++;
    if (frame_cnt !== 16'd1 || frozen !== 1'b0) begin
      errors++;
      $display("FAIL first_vbl: got cnt %0d frozen %b want 1 0", frame_cnt, frozen);
    end
    cyc(1, 16'h0102, 6'h21, 0, 0, '0, '0, 0, 0);
    checks++;
    if ({fb_we, fb_waddr, fb_wdata} !== {1'b1, 16'h0102, 6'h21}) begin
      errors++;
      $display("FAIL first_pixel: got we=%b a=%h d=%h want 1 0102 21", fb_we, fb_waddr, fb_wdata);
    end
    idle(0);
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL we_one_cycle: got %b want 0", fb_we);
    end
  endtask

  task automatic test_full_frame();
    bit exp_bank;
`ifdef NES_FB_DOUBLE_BUFFER_EN
    exp_bank = 1;
`else
    exp_bank = 0;
`endif
    run_frame(FP - 1, NEVER, 0, 0, 0);
    checks++;
    if (frame_short !== 1'b0 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL full_frame: got short %b cnt %0d want 0 2", frame_short, frame_cnt);
    end
    checks++;
    if (fb_bank !== exp_bank) begin
      errors++;
      $display("FAIL full_frame_bank: got %b want %b", fb_bank, exp_bank);
    end
  endtask

  task automatic test_short_frame();
    logic bank_before;
    bank_before = fb_bank;
    run_frame(FP - 1, NEVER, 0, 0, 0);
    checks++;
    if (frame_short !== 1'b1 || fb_bank !== bank_before) begin
      errors++;
      $display("FAIL short_frame: got short %b bank %b want 1 %b", frame_short, fb_bank, bank_before);
    end
    idle(1);
    checks++;
    if (frame_short !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: got %b want 0", frame_short);
    end
    run_frame(FP - 1, NEVER, 0, 0, 1);
    checks++;
    if (frame_short !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clr: got %b want 1", frame_short);
    end
    idle(1);
    run_frame(FP, NEVER, 0, 0, 0);
    checks++;
    if (frame_short !== 1'b0) begin
      errors++;
      $display("FAIL short_recover: got %b want 0", frame_short);
    end
  endtask

  task automatic test_back_to_back();
    hq.delete(); hcount = 0; rdy_lo = 0;
    run_frame(FP, NEVER, 0, 1, 0);
    checks++;
    if (hcount !== 3 * FP + 1 || hq.size() != 0) begin
      errors++;
      $display("FAIL host_throughput: got %0d writes (%0d pending) want %0d", hcount, hq.size(), 3 * FP + 1);
    end
    checks++;
    if (rdy_lo !== FP) begin
      errors++;
      $display("FAIL ready_low_cycles: got %0d want %0d", rdy_lo, FP);
    end
    checks++;
    if (frame_short !== 1'b0) begin
      errors++;
      $display("FAIL host_frame_short: got %b want 0", frame_short);
    end
  endtask

  task automatic test_freeze();
    logic bank_before;
    bank_before = fb_bank;
    hq.delete();
    run_frame(FP, FP / 2, 1, 1, 0);
    checks++;
    if (frozen !== 1'b1 || fb_bank !== bank_before || frame_short !== 1'b0) begin
      errors++;
      $display("FAIL enter_frozen: got frozen %b bank %b short %b want 1 %b 0",
               frozen, fb_bank, frame_short, bank_before);
    end
    hq.delete(); hcount = 0;
    run_frame(FP, 0, 0, 1, 0);
    checks++;
    if (hcount !== 4 * FP + 1) begin
      errors++;
      $display("FAIL frozen_host: got %0d writes want %0d", hcount, 4 * FP + 1);
    end
    checks++;
    if (frozen !== 1'b0 || fb_bank !== bank_before || frame_short !== 1'b0) begin
      errors++;
      $display("FAIL leave_frozen: got frozen %b bank %b short %b want 0 %b 0",
               frozen, fb_bank, frame_short, bank_before);
    end
    run_frame(FP - 1, NEVER, 0, 0, 0);
    checks++;
    if (frame_short !== 1'b1) begin
      errors++;
      $display("FAIL post_freeze_check: got %b want 1", frame_short);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, 0, 1, AW'($urandom), DW'($urandom), 0, 0);
    checks++;
    if (fb_we !== 1'b1) begin
      errors++;
      $display("FAIL burst_active: got %b want 1", fb_we);
    end
    rst_nes_n = 1'b0;
    #2;
    checks++;
    if ({fb_we, fb_waddr, fb_wdata, fb_bank, frozen, frame_short, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0",
               {fb_we, fb_waddr, fb_wdata, fb_bank, frozen, frame_short, frame_cnt});
    end
    host_valid = 1'b0;
    @(posedge clk_nes);
    #1;
    rst_nes_n = 1'b1;
    model_reset();
    hq.delete();
    we_cnt = 0;
    run_frame(4, NEVER, 0, 0, 0);
    checks++;
    if (we_cnt !== 0 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_wait: got %0d writes cnt %0d want 0 1", we_cnt, frame_cnt);
    end
    run_frame(FP, NEVER, 0, 0, 0);
    checks++;
    if (frame_short !== 1'b0 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL post_reset_frame: got short %b cnt %0d want 0 2", frame_short, frame_cnt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_nes_n = 1'b0;
    ppu_we = 0; ppu_addr = '0; ppu_data = '0; ppu_vbl = 0;
    host_valid = 0; host_addr = '0; host_data = '0; freeze = 0; clr_err = 0;
    hcount = 0; rdy_lo = 0; we_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk_nes);
    #1;
    test_reset();
    rst_nes_n = 1'b1;
    test_wait_vbl();
    test_full_frame();
    test_short_frame();
    test_back_to_back();
    test_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nes_fb_wr_arb.md
# nes_fb_wr_arb

Write-port arbiter and frame sequencer for the NES framebuffer, in the `clk_nes` domain between the PPU pixel capture logic and the framebuffer write port. It merges the PPU pixel stream, which has priority and no backpressure, with a host/OSD writer that uses a valid/ready handshake. It aligns PPU writes to whole frames and implements freeze-frame. It checks that every frame delivers 256×240 pixels and, optionally, selects the double-buffer write bank.

## Interface
- `ADDR_W`, 16: framebuffer address width, `{y[7:0], x[7:0]}`.
- `DATA_W`, 6: palette index width.
- `FRAME_PIX`, 61440: expected PPU writes per frame.
- `clk_nes` in 1: NES master clock, 21.47 MHz. The only clock.
- `rst_nes_n` in 1: asynchronous, active-low reset.
- `ppu_we` in 1: PPU pixel strobe, one cycle, at most one in every 4 cycles.
- `ppu_addr` in `ADDR_W`: PPU pixel address.
- `ppu_data` in `DATA_W`: PPU palette index.
- `ppu_vbl` in 1: one-cycle pulse at scanline 240 / cycle 1, the frame boundary.
- `host_valid` in 1: host write request.
- `host_ready` out 1: host write accepted this cycle. Combinational.
- `host_addr` in `ADDR_W`, `host_data` in `DATA_W`: host write payload.
- `freeze` in 1: level request to freeze the displayed image.
- `clr_err` in 1: clears `frame_short`.
- `fb_we` out 1, `fb_waddr` out `ADDR_W`, `fb_wdata` out `DATA_W`: framebuffer write port. All registered.
- `fb_bank` out 1: bank being written. Registered.
- `frozen` out 1: high in FROZEN state.
- `frame_cnt` out 16: `ppu_vbl` count, wraps.
- `frame_short` out 1: sticky flag, a RUN frame delivered a pixel count other than `FRAME_PIX`.

## Operation
- States:
  - WAIT_VBL (reset state): PPU writes are discarded. On `ppu_vbl` go to RUN, or to FROZEN if `freeze`=1.
  - RUN: PPU writes are forwarded. On `ppu_vbl`: if `freeze`=1 go to FROZEN, otherwise stay in RUN.
  - FROZEN: PPU writes are discarded. On `ppu_vbl` with `freeze`=0 go to RUN.
- Arbitration, per cycle:
  - A forwarded PPU write always wins.
  - `host_ready` = `~(ppu_we & state==RUN)`.
  - A host transfer occurs when `host_valid & host_ready`. Host writes are allowed in every state.
- Pixel counter: 16 bits, saturating at 65535. It counts forwarded PPU writes.
  - On `ppu_vbl` in RUN: if count ≠ `FRAME_PIX`, set `frame_short`.
  - On every `ppu_vbl`: clear the counter.
  - A `ppu_we` in the same cycle as `ppu_vbl` is counted into the new frame.
- `frame_short` and `clr_err` in the same cycle: set wins.
- `frame_cnt` increments on every `ppu_vbl` in all states, and wraps 65535→0.

## Timing
- Reset values: `fb_we`=0, `fb_waddr`=0, `fb_wdata`=0, `fb_bank`=0, `frozen`=0, `frame_cnt`=0, `frame_short`=0, state WAIT_VBL, pixel count 0.
- Latency: `ppu_we` or a host transfer at cycle N produces `fb_we`=1 with the matching address and data at N+1. `fb_we` lasts exactly one cycle per transfer.
- Discarded PPU writes: `fb_we` stays 0, unless a host transfer occurs in the same cycle.
- `frozen` is registered and reflects the state from the cycle after the transition.
- If reset is asserted mid-frame: all outputs clear asynchronously. After release, the block waits for the next `ppu_vbl` before writing any PPU data.
- Host writes issued while `ppu_we` is forwarded stall for exactly 1 cycle. Because PPU strobes are spaced at least 4 cycles apart, host throughput is at least 3 writes per 4 cycles.

## Configuration
- `NES_FB_DOUBLE_BUFFER_EN` defined:
  - On `ppu_vbl` in RUN with the next state RUN, and only when the closing frame had count = `FRAME_PIX`, `fb_bank` toggles at the next cycle.
  - Short frames do not flip.
  - FROZEN holds `fb_bank`.
  - The display side reads `~fb_bank`.
- Undefined: `fb_bank` is tied to 0, there is single-buffer behaviour, and all other behaviour is identical.

## Test plan
- Reset, then 3 `ppu_we` before the first `ppu_vbl` → no `fb_we`. After `ppu_vbl`, `ppu_we` with addr 0x0102 and data 0x21 → `fb_we`=1 next cycle with `fb_waddr`=0x0102 and `fb_wdata`=0x21.
- Full frame of 61440 strobes every 4 cycles, then `ppu_vbl` → `frame_short`=0 and `frame_cnt`=2. With the macro, `fb_bank` goes 0→1.
- Frame with 61439 strobes → `frame_short`=1 after `ppu_vbl`, `fb_bank` unchanged. `clr_err` clears it. `clr_err` coincident with a second short frame → flag stays 1.
- `host_valid` held high while `ppu_we` pulses every 4 cycles in RUN → `host_ready`=0 only in the `ppu_we` cycles. Exactly 3 host writes per 4 cycles appear on `fb_*` in order, with none lost or duplicated.
- `freeze`=1 mid-frame → PPU writes continue until `ppu_vbl`, then `frozen`=1 and PPU writes are discarded. Host writes still land. Drop `freeze`, then `ppu_vbl` → RUN, and the next frame is checked.
- Assert `rst_nes_n`=0 mid-host-burst → all outputs 0 immediately (asynchronous). After release → WAIT_VBL behaviour.
